audio_mixer: RTL

//  Downstream stage of the per-voice Channel blocks. On each sample-rate tick it snapshots every channel's
//  o_SampleOut and mixes the playing channels into one stereo frame, routing each by isMono/isRight.
//  It then applies master volume and saturates the result. The frame goes to the I2S serializer over valid/ready.

---
 rtl/audio_mixer_pkg.sv | 16 +
 rtl/audio_mixer_if.sv | 21 ++
 rtl/audio_mixer_saturate.sv | 24 ++
 rtl/audio_mixer.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/audio_mixer_pkg.sv
// rtl/audio_mixer_pkg.sv - shared types and constants for the audio mixer
package audio_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        SCALE  = 2'd2,
        OUTPUT = 2'd3
    } mixer_state_t;

    localparam int SAMPLE_W = 16;
    localparam logic [7:0] UNITY_VOLUME = 8'd128;
    localparam logic signed [SAMPLE_W-1:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [SAMPLE_W-1:0] SAT_MIN = 16'sh8000;

endpackage

// File: rtl/audio_mixer_if.sv
// rtl/audio_mixer_if.sv - stereo frame handshake from mixer to serializer
interface audio_mixer_if;
    logic signed [15:0] o_left;
    logic signed [15:0] o_right;
    logic               o_valid;
    logic               i_ready;

    modport master (
        output o_left,
        output o_right,
        output o_valid,
        input  i_ready
    );

    modport slave (
        input  o_left,
        input  o_right,
        input  o_valid,
        output i_ready
    );
endinterface

// File: rtl/audio_mixer_saturate.sv
// rtl/audio_mixer_saturate.sv - clamp a wide signed value to a signed 16-bit sample
module audio_saturate
    import audio_pkg::*;
#(
    parameter int IN_W = 28
) (
    input  logic signed [IN_W-1:0]     value,
    output logic signed [SAMPLE_W-1:0] clamped
);

    localparam logic signed [IN_W-1:0] MAX_EXT = IN_W'(SAT_MAX);
    localparam logic signed [IN_W-1:0] MIN_EXT = IN_W'(SAT_MIN);

    // Pass the low bits through when in range, otherwise pin to the rail
    always_comb begin
        clamped = value[SAMPLE_W-1:0];
        if (value > MAX_EXT) begin
            clamped = SAT_MAX;
        end else if (value < MIN_EXT) begin
            clamped = SAT_MIN;
        end
    end

endmodule

// File: rtl/audio_mixer.sv
// rtl/audio_mixer.sv - per-tick stereo mixer with master volume; optional AUDIO_MIXER_MUTE_EN adds per-channel mute
module audio_mixer #(
    parameter int NUM_CHANNELS = 8,
    parameter int SAMPLE_W     = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_tick,
    input  logic [NUM_CHANNELS*SAMPLE_W-1:0] i_sample,
    input  logic [NUM_CHANNELS-1:0]          i_isPlaying,
    input  logic [NUM_CHANNELS-1:0]          i_isMono,
    input  logic [NUM_CHANNELS-1:0]          i_isRight,
    input  logic [7:0]                       i_masterVolume,
`ifdef AUDIO_MIXER_MUTE_EN
    input  logic [NUM_CHANNELS-1:0]          i_mute,
`endif
    audio_mixer_if.master                    frameIf,
    output logic                             o_busy,
    output logic                             o_overrun
);
    import audio_pkg::*;

    localparam int IDX_W  = $clog2(NUM_CHANNELS);
    localparam int ACC_W  = SAMPLE_W + IDX_W;
    localparam int PROD_W = ACC_W + 9;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHANNELS - 1);

    mixer_state_t state;
    mixer_state_t stateNext;

    logic [NUM_CHANNELS*SAMPLE_W-1:0] sampleSnap;
    logic [NUM_CHANNELS-1:0]          playSnap;
    logic [NUM_CHANNELS-1:0]          monoSnap;
    logic [NUM_CHANNELS-1:0]          rightSnap;
    logic [NUM_CHANNELS-1:0]          liveNow;
    logic [IDX_W-1:0]                 idx;
    logic                             scalePhase;
    logic signed [ACC_W-1:0]          accL;
    logic signed [ACC_W-1:0]          accR;
    logic signed [ACC_W-1:0]          curSample;
    logic signed [PROD_W-1:0]         prodL;
    logic signed [PROD_W-1:0]         prodR;
    logic signed [PROD_W-1:0]         resL;
    logic signed [PROD_W-1:0]         resR;
    logic signed [15:0]               satL;
    logic signed [15:0]               satR;
    logic signed [15:0]               leftReg;
    logic signed [15:0]               rightReg;
    logic                             overrun;

`ifdef AUDIO_MIXER_MUTE_EN
    assign liveNow = i_isPlaying & ~i_mute;
`else
    assign liveNow = i_isPlaying;
`endif

    assign curSample = ACC_W'($signed(sampleSnap[idx*SAMPLE_W +: SAMPLE_W]));
    assign resL      = prodL >>> 7;
    assign resR      = prodR >>> 7;

    assign frameIf.o_left  = leftReg;
    assign frameIf.o_right = rightReg;
    assign o_overrun       = overrun;

    audio_saturate #(.IN_W(PROD_W)) u_satLeft (
        .value   (resL),
        .clamped (satL)
    );

    audio_saturate #(.IN_W(PROD_W)) u_satRight (
        .value   (resR),
        .clamped (satR)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state and status decode; SCALE spends one cycle multiplying and one saturating
    always_comb begin
        stateNext       = state;
        o_busy          = (state != IDLE);
        frameIf.o_valid = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_tick) begin
                    stateNext = ACCUM;
                end
            end
            ACCUM: begin
                if (idx == LAST_IDX) begin
                    stateNext = SCALE;
                end
            end
            SCALE: begin
                if (scalePhase) begin
                    stateNext = OUTPUT;
                end
            end
            OUTPUT: begin
                frameIf.o_valid = 1'b1;
                if (frameIf.i_ready) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Snapshot, accumulate, scale and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            sampleSnap <= '0;
            playSnap   <= '0;
            monoSnap   <= '0;
            rightSnap  <= '0;
            idx        <= '0;
            scalePhase <= 1'b0;
            accL       <= '0;
            accR       <= '0;
            prodL      <= '0;
            prodR      <= '0;
            leftReg    <= '0;
            rightReg   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_tick) begin
                        sampleSnap <= i_sample;
                        playSnap   <= liveNow;
                        monoSnap   <= i_isMono;
                        rightSnap  <= i_isRight;
                        accL       <= '0;
                        accR       <= '0;
                        idx        <= '0;
                        scalePhase <= 1'b0;
                    end
                end
                ACCUM: begin
                    if (playSnap[idx]) begin
                        if (monoSnap[idx]) begin
                            accL <= accL + curSample;
                            accR <= accR + curSample;
                        end else if (rightSnap[idx]) begin
                            accR <= accR + curSample;
                        end else begin
                            accL <= accL + curSample;
                        end
                    end
                    idx <= idx + 1'b1;
                end
                SCALE: begin
                    if (!scalePhase) begin
                        prodL      <= accL * $signed({1'b0, i_masterVolume});
                        prodR      <= accR * $signed({1'b0, i_masterVolume});
                        scalePhase <= 1'b1;
                    end else begin
                        leftReg    <= satL;
                        rightReg   <= satR;
                        scalePhase <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sticky flag for ticks that arrive while a frame is in flight
    always_ff @(posedge clk) begin
        if (!rst) begin
            overrun <= 1'b0;
        end else if (i_tick && (state != IDLE)) begin
            overrun <= 1'b1;
        end
    end

endmodule
